sd_bit_timer: RTL and testbench

Parametrised SD-bus bit timer, the successor to the fixed divide-by-8 timer in the SD front end. It generates `sd_clk` from `clk` with two run-time-selectable divisors: slow for card identification, fast for transfer. It emits one drive strobe and one sample strobe per SD clock period and counts bits into words of run-time length, 8 for data bytes and 48 for command/response frames. It sits between the SD command/data shift registers and the controller FSM. The clock starts and stops only at period boundaries, so `sd_clk` never produces a runt pulse.

---
 rtl/sd_timer_pkg.sv | 22 ++
 rtl/sd_bit_timer_if.sv | 28 ++
 rtl/sd_clk_gen.sv | 99 +++++++++
 rtl/sd_bit_timer.sv | 72 +++++++
 tb/tb_sd_bit_timer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/sd_timer_pkg.sv
// sd_timer_pkg: shared constants and types for the SD bit timer slice.
//   SD_DIV_SLOW / SD_DIV_FAST : default clk cycles per sd_clk period (card-id / transfer)
//   SD_WORD_LEN_DATA / _CMD   : word lengths for data bytes and command/response frames
//   sd_phase_t                : phase counter type at the default width
package sd_timer_pkg;

  localparam int unsigned SD_DIV_SLOW      = 250;
  localparam int unsigned SD_DIV_FAST      = 8;
  localparam int unsigned SD_DIV_W         = 8;
  localparam int unsigned SD_WORD_LEN_DATA = 8;
  localparam int unsigned SD_WORD_LEN_CMD  = 48;
  // Wide enough to hold a full command frame length.
  localparam int unsigned SD_BITS_W        = $clog2(SD_WORD_LEN_CMD + 1);

  typedef logic [SD_DIV_W-1:0] sd_phase_t;

  typedef enum logic {
    SD_IDLE = 1'b0,
    SD_RUN  = 1'b1
  } sd_run_state_e;

endpackage

// File: rtl/sd_bit_timer_if.sv
// sd_bit_timer_if: controller <-> bit timer bundle.
//   master : controller side (drives enable/fast_mode/word_len/clear_word)
//   slave  : timer side (drives sd_clk, strobes, bit_count, word_done, busy, fast_active)
interface sd_bit_timer_if #(
  parameter int unsigned BITS_W = sd_timer_pkg::SD_BITS_W
);
  logic              enable;
  logic              fast_mode;
  logic [BITS_W-1:0] word_len;
  logic              clear_word;
  logic              sd_clk;
  logic              fall_strobe;
  logic              rise_strobe;
  logic [BITS_W-1:0] bit_count;
  logic              word_done;
  logic              busy;
  logic              fast_active;

  modport master (
    output enable, fast_mode, word_len, clear_word,
    input  sd_clk, fall_strobe, rise_strobe, bit_count, word_done, busy, fast_active
  );

  modport slave (
    input  enable, fast_mode, word_len, clear_word,
    output sd_clk, fall_strobe, rise_strobe, bit_count, word_done, busy, fast_active
  );
endinterface

// File: rtl/sd_clk_gen.sv
// sd_clk_gen: phase counter, divisor latch, sd_clk and drive/sample strobes.
//   clk, rst     : system clock, async active-high reset
//   enable       : run request, only honoured at period boundaries
//   fast_mode    : divisor select, loaded at each period start
//   sd_clk       : low for first half of period, high for second half
//   fall_strobe  : first cycle of each period
//   rise_strobe  : first cycle sd_clk is high
//   busy         : a period is in progress
//   fast_active  : divisor in use for the current period
//   rise_next_c  : rise_strobe will be set at the next edge (lets the parent align word_done)
module sd_clk_gen
  import sd_timer_pkg::*;
#(
  parameter int unsigned SLOW_DIV = SD_DIV_SLOW,
  parameter int unsigned FAST_DIV = SD_DIV_FAST,
  parameter int unsigned DIV_W    = SD_DIV_W
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic fast_mode,
  output logic sd_clk,
  output logic fall_strobe,
  output logic rise_strobe,
  output logic busy,
  output logic fast_active,
  output logic rise_next_c
);

  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] SLOW_HALF = DIV_W'(SLOW_DIV / 2);
  localparam logic [DIV_W-1:0] FAST_LAST = DIV_W'(FAST_DIV - 1);
  localparam logic [DIV_W-1:0] FAST_HALF = DIV_W'(FAST_DIV / 2);

  sd_run_state_e    state_q, state_d;
  logic [DIV_W-1:0] phase_q, phase_d, phase_inc_c, last_c, half_c;
  logic             sd_clk_d, fall_d, fast_d;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SD_IDLE;
      phase_q     <= '0;
      sd_clk      <= 1'b0;
      fall_strobe <= 1'b0;
      rise_strobe <= 1'b0;
      fast_active <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      sd_clk      <= sd_clk_d;
      fall_strobe <= fall_d;
      rise_strobe <= rise_next_c;
      fast_active <= fast_d;
    end
  end

  // Next state: enable is only looked at when idle or on the last phase,
  // so a period is never cut short and never starts mid-way.
  always_comb begin
    state_d     = state_q;
    phase_d     = '0;
    sd_clk_d    = 1'b0;
    fall_d      = 1'b0;
    rise_next_c = 1'b0;
    fast_d      = fast_active;
    last_c      = fast_active ? FAST_LAST : SLOW_LAST;
    half_c      = fast_active ? FAST_HALF : SLOW_HALF;
    phase_inc_c = phase_q + DIV_W'(1);

    case (state_q)
      SD_IDLE: begin
        if (enable) begin
          state_d = SD_RUN;
          fall_d  = 1'b1;
          fast_d  = fast_mode;
        end
      end
      SD_RUN: begin
        if (phase_q == last_c) begin
          if (enable) begin
            fall_d = 1'b1;
            fast_d = fast_mode;
          end else begin
            state_d = SD_IDLE;
          end
        end else begin
          phase_d     = phase_inc_c;
          sd_clk_d    = (phase_inc_c >= half_c);
          rise_next_c = (phase_inc_c == half_c);
        end
      end
      default: state_d = SD_IDLE;
    endcase
  end

  assign busy = (state_q == SD_RUN);

endmodule

// File: rtl/sd_bit_timer.sv
// sd_bit_timer: SD bus bit timer with run-time divisor and word length.
//   clk, rst : system clock, async active-high reset
//   bus      : slave side of sd_bit_timer_if (controls in, clock/strobes/counters out)
// The clock generator is in sd_clk_gen; this level latches the word length,
// counts completed rising edges and flags the last bit of each word.
module sd_bit_timer
  import sd_timer_pkg::*;
#(
  parameter int unsigned SLOW_DIV = SD_DIV_SLOW,
  parameter int unsigned FAST_DIV = SD_DIV_FAST,
  parameter int unsigned DIV_W    = SD_DIV_W,
  parameter int unsigned BITS_W   = SD_BITS_W
) (
  input  logic           clk,
  input  logic           rst,
  sd_bit_timer_if.slave  bus
);

  logic              rise_next_c;
  logic [BITS_W-1:0] len_q, wl_sat_c, len_eff_c, bit_count_d;
  logic              word_done_d, word_start_c;

  sd_clk_gen #(
    .SLOW_DIV (SLOW_DIV),
    .FAST_DIV (FAST_DIV),
    .DIV_W    (DIV_W)
  ) u_clk_gen (
    .clk         (clk),
    .rst         (rst),
    .enable      (bus.enable),
    .fast_mode   (bus.fast_mode),
    .sd_clk      (bus.sd_clk),
    .fall_strobe (bus.fall_strobe),
    .rise_strobe (bus.rise_strobe),
    .busy        (bus.busy),
    .fast_active (bus.fast_active),
    .rise_next_c (rise_next_c)
  );

  // word_done is launched by the edge that launches rise_strobe, so the
  // last-bit test runs one cycle early. When that cycle is also the word's
  // first fall_strobe (two-cycle period) the latch has not loaded yet, so
  // the length is taken straight from the input.
  always_comb begin
    wl_sat_c     = (bus.word_len == '0) ? BITS_W'(1) : bus.word_len;
    word_start_c = bus.fall_strobe && (bus.bit_count == '0);
    len_eff_c    = word_start_c ? wl_sat_c : len_q;
    word_done_d  = rise_next_c && !bus.clear_word &&
                   (bus.bit_count == len_eff_c - BITS_W'(1));

    bit_count_d = bus.bit_count;
    if (bus.clear_word) begin
      bit_count_d = '0;
    end else if (bus.rise_strobe) begin
      bit_count_d = bus.word_done ? '0 : bus.bit_count + BITS_W'(1);
    end
  end

  // Word length latch, bit counter and word_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q         <= BITS_W'(SD_WORD_LEN_DATA);
      bus.bit_count <= '0;
      bus.word_done <= 1'b0;
    end else begin
      if (word_start_c) len_q <= wl_sat_c;
      bus.bit_count <= bit_count_d;
      bus.word_done <= word_done_d;
    end
  end

endmodule

// File: tb/tb_sd_bit_timer.sv
// tb_sd_bit_timer: directed self-checking bench for sd_bit_timer
// (SLOW_DIV=250, FAST_DIV=8). Outputs are observed and inputs driven on the
// falling clock edge; k=0 is the first cycle after enable is sampled high.
module tb_sd_bit_timer;
  import sd_timer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sd_bit_timer_if #(.BITS_W(6)) bus ();

  sd_bit_timer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {sd_clk, fall, rise, word_done, busy, fast_active, bit_count}
  function automatic logic [11:0] obs();
    return {bus.sd_clk, bus.fall_strobe, bus.rise_strobe, bus.word_done,
            bus.busy, bus.fast_active, bus.bit_count};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.clear_word = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.fast_mode = 1'b1;
    bus.word_len = 6'd8;
    bus.clear_word = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs() !== 12'h000) begin
      n_err++;
      $display("FAIL reset_held got=%h exp=000", obs());
    end
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== 12'h000) begin
        n_err++;
        $display("FAIL idle k=%0d got=%h exp=000", k, obs());
      end
    end
  endtask

  task automatic test_fast_word();
    logic [11:0] exp;
    int ph;
    do_reset();
    bus.fast_mode = 1'b1;
    bus.word_len = 6'd8;
    bus.enable = 1'b1;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      ph = k % 8;
      exp = {ph >= 4, ph == 0, ph == 4, (k % 64) == 60, 1'b1, 1'b1,
             6'(((k + 3) / 8) % 8)};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL fast_word k=%0d got=%h exp=%h", k, obs(), exp);
      end
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_mode_switch();
    logic [4:0] exp, got;
    do_reset();
    bus.fast_mode = 1'b0;
    bus.word_len = 6'd8;
    bus.enable = 1'b1;
    for (int k = 0; k <= 266; k++) begin
      @(negedge clk);
      exp = {(k >= 125 && k < 250) || (k >= 254 && k < 258) || (k >= 262 && k < 266),
             k == 0 || k == 250 || k == 258 || k == 266,
             k == 125 || k == 254 || k == 262,
             1'b1,
             k >= 250};
      got = {bus.sd_clk, bus.fall_strobe, bus.rise_strobe, bus.busy, bus.fast_active};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL mode_switch k=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 10) bus.fast_mode = 1'b1;
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_stop();
    logic [3:0] exp, got;
    int ph;
    do_reset();
    bus.fast_mode = 1'b1;
    bus.word_len = 6'd8;
    bus.enable = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      ph = k % 8;
      exp = (k < 8) ? {ph >= 4, ph == 0, ph == 4, 1'b1} : 4'b0000;
      got = {bus.sd_clk, bus.fall_strobe, bus.rise_strobe, bus.busy};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL stop k=%0d got=%b exp=%b", k, got, exp);
      end
      if (k == 5) bus.enable = 1'b0;
    end
    n_cmp++;
    if (bus.bit_count !== 6'd1) begin
      n_err++;
      $display("FAIL stop_bit_count got=%0d exp=1", bus.bit_count);
    end
  endtask

  task automatic test_clear();
    do_reset();
    bus.fast_mode = 1'b1;
    bus.word_len = 6'd48;
    bus.enable = 1'b1;
    for (int k = 0; k <= 920; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.word_done !== (k == 916)) begin
        n_err++;
        $display("FAIL clear_done k=%0d got=%b exp=%b", k, bus.word_done, k == 916);
      end
      if (k == 380) begin
        n_cmp++;
        if ({bus.rise_strobe, bus.bit_count} !== {1'b1, 6'd0}) begin
          n_err++;
          $display("FAIL clear_last_bit rise=%b cnt=%0d exp rise=1 cnt=0",
                   bus.rise_strobe, bus.bit_count);
        end
      end
      if (k == 381 || k == 536 || k == 537 || k == 916 || k == 917) begin
        int e;
        e = (k == 381) ? 1 : (k == 536) ? 20 : (k == 916) ? 47 : 0;
        n_cmp++;
        if (bus.bit_count !== 6'(e)) begin
          n_err++;
          $display("FAIL clear_count k=%0d got=%0d exp=%0d", k, bus.bit_count, e);
        end
      end
      if (k == 379 || k == 536) bus.clear_word = 1'b1;
      if (k == 380 || k == 537) bus.clear_word = 1'b0;
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_word_len();
    logic [6:0] exp, got;
    int c;
    do_reset();
    bus.fast_mode = 1'b1;
    bus.word_len = 6'd0;
    bus.enable = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (k < 16) begin
        exp = {(k % 8) == 4, 6'd0};
      end else begin
        c = (k - 13) / 8;
        exp = {(k % 8) == 4 && (c % 3) == 2, 6'(c % 3)};
      end
      got = {bus.word_done, bus.bit_count};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL word_len k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 10) bus.word_len = 6'd3;
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [11:0] exp;
    do_reset();
    bus.fast_mode = 1'b1;
    bus.word_len = 6'd8;
    bus.enable = 1'b1;
    repeat (38) @(negedge clk);
    n_cmp++;
    if (bus.bit_count !== 6'd5) begin
      n_err++;
      $display("FAIL pre_reset_count got=%0d exp=5", bus.bit_count);
    end
    #2 rst = 1'b1;
    bus.fast_mode = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 12'h000) begin
      n_err++;
      $display("FAIL async_reset got=%h exp=000", obs());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k <= 130; k++) begin
      @(negedge clk);
      exp = {k >= 125, k == 0, k == 125, 1'b0, 1'b1, 1'b0, 6'(k > 125 ? 1 : 0)};
      n_cmp++;
      if (obs() !== exp) begin
        n_err++;
        $display("FAIL restart k=%0d got=%h exp=%h", k, obs(), exp);
      end
    end
    bus.enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fast_word();
    test_mode_switch();
    test_stop();
    test_clear();
    test_word_len();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
